// File: rtl/adsr_envelope_4bit_pkg.sv
// Shared types and constants for the 4-bit ADSR envelope generator.
// Phase encoding, level limits and the per-phase rate selector live here.
package adsr_env_pkg;

  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'hF;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_e;

  // Step period (minus one) used by a given phase; non-ramp phases use 0.
  function automatic logic [LEVEL_W-1:0] rate_for(
    input phase_e                ph,
    input logic [LEVEL_W-1:0]    atk_rate,
    input logic [LEVEL_W-1:0]    dec_rate,
    input logic [LEVEL_W-1:0]    rel_rate
  );
    case (ph)
      PH_ATTACK:  return atk_rate;
      PH_DECAY:   return dec_rate;
      PH_RELEASE: return rel_rate;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/adsr_envelope_4bit_if.sv
// Control/status bundle between the note/gate logic and the envelope.
// master = gate/rate driver, slave = envelope generator.
interface adsr_envelope_4bit_if;
  logic                             gate;
  logic [adsr_env_pkg::LEVEL_W-1:0] attack_rate;
  logic [adsr_env_pkg::LEVEL_W-1:0] decay_rate;
  logic [adsr_env_pkg::LEVEL_W-1:0] sustain_level;
  logic [adsr_env_pkg::LEVEL_W-1:0] release_rate;
  logic [adsr_env_pkg::LEVEL_W-1:0] level;
  logic [2:0]                       phase;
  logic                             busy;
  logic                             done;

  modport master (
    output gate, attack_rate, decay_rate, sustain_level, release_rate,
    input  level, phase, busy, done
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_level, release_rate,
    output level, phase, busy, done
  );
endinterface

// File: rtl/adsr_envelope_4bit_prescaler.sv
// Reloadable 4-bit down-counter that paces envelope steps.
// step is high while the count is zero; the counter then reloads rate.
module env_rate_prescaler
  import adsr_env_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [LEVEL_W-1:0] rate,
  output logic               step
);

  logic [LEVEL_W-1:0] count_q;
  logic [LEVEL_W-1:0] count_d;

  // Reload on phase entry or on a step, otherwise count down.
  always_comb begin
    count_d = count_q - LEVEL_W'(1);
    if (load || (count_q == '0)) begin
      count_d = rate;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign step = (count_q == '0);

endmodule

// File: rtl/adsr_envelope_4bit.sv
// 4-bit ADSR envelope generator: attack up to 15, decay to sustain,
// hold while gated, release to zero after the gate falls.
// Optional build macro ADSR_ENV_RETRIGGER_EN: a gate rising edge in any
// active phase restarts ATTACK from the current level.
module adsr_envelope_4bit
  import adsr_env_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  adsr_envelope_4bit_if.slave  env
);

  logic               gate_q;
  logic               rise_q;
  phase_e             phase_q;
  phase_e             phase_d;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic               done_q;
  logic               done_d;
  logic               reload;
  logic [LEVEL_W-1:0] rate_sel;
  logic               step;

  env_rate_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .load  (reload),
    .rate  (rate_sel),
    .step  (step)
  );

  // Gate history: a rising edge is registered so it acts one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      gate_q <= env.gate;
      rise_q <= env.gate & ~gate_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      level_q <= '0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
      done_q  <= done_d;
    end
  end

  // FSM next-state: gate-low beats a step; a phase change reloads the prescaler.
  always_comb begin
    phase_d = phase_q;
    level_d = level_q;
    done_d  = 1'b0;
    reload  = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        level_d = '0;
        if (rise_q) phase_d = PH_ATTACK;
      end
      PH_ATTACK: begin
        if (!env.gate) begin
          phase_d = PH_RELEASE;
        end
`ifdef ADSR_ENV_RETRIGGER_EN
        else if (rise_q) begin
          reload = 1'b1;
        end
`endif
        else if (step) begin
          if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
          if (level_q >= (LEVEL_MAX - LEVEL_W'(1))) phase_d = PH_DECAY;
        end
      end
      PH_DECAY: begin
        if (!env.gate) begin
          phase_d = PH_RELEASE;
        end
`ifdef ADSR_ENV_RETRIGGER_EN
        else if (rise_q) begin
          phase_d = PH_ATTACK;
        end
`endif
        else if (level_q <= env.sustain_level) begin
          phase_d = PH_SUSTAIN;
        end else if (step) begin
          level_d = level_q - LEVEL_W'(1);
          if (level_d == env.sustain_level) phase_d = PH_SUSTAIN;
        end
      end
      PH_SUSTAIN: begin
        if (!env.gate) begin
          phase_d = PH_RELEASE;
        end
`ifdef ADSR_ENV_RETRIGGER_EN
        else if (rise_q) begin
          phase_d = PH_ATTACK;
        end
`endif
      end
      PH_RELEASE: begin
`ifdef ADSR_ENV_RETRIGGER_EN
        if (rise_q) begin
          phase_d = PH_ATTACK;
        end else
`endif
        if (level_q == '0) begin
          phase_d = PH_IDLE;
        end else if (step) begin
          level_d = level_q - LEVEL_W'(1);
          if (level_q == LEVEL_W'(1)) begin
            phase_d = PH_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        phase_d = PH_IDLE;
        level_d = '0;
      end
    endcase
    if (phase_d != phase_q) reload = 1'b1;
  end

  // Prescaler reload value: the entered phase's rate on entry, else the current one.
  always_comb begin
    rate_sel = rate_for(reload ? phase_d : phase_q,
                        env.attack_rate, env.decay_rate, env.release_rate);
  end

  // FSM outputs: straight decode of the state registers.
  always_comb begin
    env.level = level_q;
    env.phase = phase_q;
    env.busy  = (phase_q != PH_IDLE);
    env.done  = done_q;
  end

endmodule

// File: tb/tb_adsr_envelope_4bit.sv
// Bench for adsr_envelope_4bit: vector table, directed corner sequences,
// then randomized gate/rate traffic against an event-time reference model.
module tb_adsr_envelope_4bit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adsr_envelope_4bit_if bus ();

  adsr_envelope_4bit dut (
    .clk   (clk),
    .reset (reset),
    .env   (bus)
  );

`ifdef ADSR_ENV_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int rst; int gate; int ar; int dr; int sl; int rr;
    int cycles;
    int lvl; int ph; int dn;
  } vec_t;
  vec_t vq[$];

  task automatic add(input int r, g, ar, dr, sl, rr, n, l, p, d);
    vec_t v;
    v = '{r, g, ar, dr, sl, rr, n, l, p, d};
    vq.push_back(v);
  endtask

  task automatic drive(input int r, g, ar, dr, sl, rr);
    reset             = 1'(r);
    bus.gate          = 1'(g);
    bus.attack_rate   = 4'(ar);
    bus.decay_rate    = 4'(dr);
    bus.sustain_level = 4'(sl);
    bus.release_rate  = 4'(rr);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int l, input int p, input int d);
    check({tag, ".level"}, 32'(bus.level), l);
    check({tag, ".phase"}, 32'(bus.phase), p);
    check({tag, ".busy"},  32'(bus.busy),  (p != 0) ? 1 : 0);
    check({tag, ".done"},  32'(bus.done),  d);
  endtask

  task automatic wait_state(input string name, input int l, input int p, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (int'(bus.level) == l && int'(bus.phase) == p) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, level=%0d phase=%0d, required level=%0d phase=%0d",
               name, budget, bus.level, bus.phase, l, p);
    end
  endtask

  task automatic reset_dut();
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference model: tracks the absolute edge number of the next step.
  int t = 0;
  int m_phase = 0, m_level = 0, m_done = 0, m_gate_prev = 0, m_rise = 0, m_next = 0;

  task automatic m_enter(input int p, input int rate);
    m_phase = p;
    m_next  = t + rate + 1;
  endtask

  task automatic model_edge(input int r, g, ar, dr, sl, rr);
    int rise_now;
    bit stp;
    t++;
    if (r != 0) begin
      m_phase = 0; m_level = 0; m_done = 0; m_gate_prev = 0; m_rise = 0;
      return;
    end
    rise_now = (g != 0 && m_gate_prev == 0) ? 1 : 0;
    stp = (t == m_next);
    m_done = 0;
    case (m_phase)
      0: if (m_rise != 0) m_enter(1, ar);
      1: begin
        if (g == 0) m_enter(4, rr);
        else if (RETRIG && m_rise != 0) m_enter(1, ar);
        else if (stp) begin
          if (m_level < 15) m_level++;
          if (m_level == 15) m_enter(2, dr);
          else m_next = t + ar + 1;
        end
      end
      2: begin
        if (g == 0) m_enter(4, rr);
        else if (RETRIG && m_rise != 0) m_enter(1, ar);
        else if (m_level <= sl) m_enter(3, 0);
        else if (stp) begin
          m_level--;
          if (m_level == sl) m_enter(3, 0);
          else m_next = t + dr + 1;
        end
      end
      3: begin
        if (g == 0) m_enter(4, rr);
        else if (RETRIG && m_rise != 0) m_enter(1, ar);
      end
      default: begin
        if (RETRIG && m_rise != 0) m_enter(1, ar);
        else if (m_level == 0) m_enter(0, 0);
        else if (stp) begin
          m_level--;
          if (m_level == 0) begin
            m_enter(0, 0);
            m_done = 1;
          end else begin
            m_next = t + rr + 1;
          end
        end
      end
    endcase
    m_rise = rise_now;
    m_gate_prev = g;
  endtask

  initial begin
    int dcount;
    int rg, rar, rdr, rsl, rrr, rrst;
    drive(1, 0, 0, 0, 8, 0);

    //   rst gate ar dr sl rr  cyc   lvl ph done
    add(1, 0, 0, 0,  8, 0,  2,    0, 0, 0);
    add(0, 1, 0, 0,  8, 0,  1,    0, 0, 0);
    add(0, 1, 0, 0,  8, 0,  1,    0, 1, 0);
    add(0, 1, 0, 0,  8, 0,  1,    1, 1, 0);
    add(0, 1, 0, 0,  8, 0, 13,   14, 1, 0);
    add(0, 1, 0, 0,  8, 0,  1,   15, 2, 0);
    add(0, 1, 0, 0,  8, 0,  1,   14, 2, 0);
    add(0, 1, 0, 0,  8, 0,  5,    9, 2, 0);
    add(0, 1, 0, 0,  8, 0,  1,    8, 3, 0);
    add(0, 1, 0, 0,  2, 0,  3,    8, 3, 0);
    add(0, 0, 0, 0,  2, 1,  1,    8, 4, 0);
    add(0, 0, 0, 0,  2, 1,  2,    7, 4, 0);
    add(0, 0, 0, 0,  2, 1, 12,    1, 4, 0);
    add(0, 0, 0, 0,  2, 1,  1,    1, 4, 0);
    add(0, 0, 0, 0,  2, 1,  1,    0, 0, 1);
    add(0, 0, 0, 0,  2, 1,  1,    0, 0, 0);
    add(0, 1, 3, 0,  2, 1,  2,    0, 1, 0);
    add(0, 1, 3, 0,  2, 1,  3,    0, 1, 0);
    add(0, 1, 3, 0,  2, 1,  1,    1, 1, 0);
    add(0, 1, 3, 0,  2, 1,  4,    2, 1, 0);
    add(0, 1, 3, 0,  2, 1, 16,    6, 1, 0);
    add(0, 0, 3, 0,  2, 1,  1,    6, 4, 0);
    add(0, 0, 3, 0,  2, 1, 11,    1, 4, 0);
    add(0, 0, 3, 0,  2, 1,  1,    0, 0, 1);
    add(0, 0, 3, 0,  2, 1,  1,    0, 0, 0);
    add(0, 1, 0, 0, 15, 0,  2,    0, 1, 0);
    add(0, 1, 0, 0, 15, 0, 15,   15, 2, 0);
    add(0, 1, 0, 0, 15, 0,  1,   15, 3, 0);
    add(0, 0, 0, 0, 15, 0,  1,   15, 4, 0);
    add(0, 0, 0, 0, 15, 0, 15,    0, 0, 1);
    add(0, 1, 0, 0,  0, 0,  2,    0, 1, 0);
    add(0, 1, 0, 0,  0, 0, 30,    0, 3, 0);
    add(0, 0, 0, 0,  0, 0,  1,    0, 4, 0);
    add(0, 0, 0, 0,  0, 0,  1,    0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].gate, vq[i].ar, vq[i].dr, vq[i].sl, vq[i].rr);
      repeat (vq[i].cycles) @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vq[i].lvl, vq[i].ph, vq[i].dn);
      $display("vec %0d: gate=%0d level=%0d phase=%0d busy=%0b done=%0b",
               i, vq[i].gate, bus.level, bus.phase, bus.busy, bus.done);
    end

    // Reset pulsed mid-DECAY at level 12.
    reset_dut();
    drive(0, 1, 0, 1, 2, 0);
    wait_state("reach_decay12", 12, 2, 60);
    drive(1, 0, 0, 1, 2, 0);
    @(posedge clk); #1;
    check_outs("rst_mid_decay", 0, 0, 0);
    $display("seq rst_mid_decay: level=%0d phase=%0d done=%0b", bus.level, bus.phase, bus.done);

    // Gate re-rises during RELEASE at level 5.
    reset_dut();
    drive(0, 1, 0, 0, 10, 7);
    wait_state("reach_sustain10", 10, 3, 60);
    drive(0, 0, 0, 0, 10, 7);
    wait_state("reach_release5", 5, 4, 200);
    drive(0, 1, 0, 0, 10, 7);
    repeat (2) @(posedge clk);
    #1;
`ifdef ADSR_ENV_RETRIGGER_EN
    check_outs("retrigger_from5", 5, 1, 0);
`else
    check_outs("ignore_rise_in_release", 5, 4, 0);
    dcount = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcount++;
    end
    check_outs("release_done_gate_high", 0, 0, 0);
    check("done_pulse_count", 32'(dcount), 1);
`endif
    $display("seq rerise_in_release: level=%0d phase=%0d", bus.level, bus.phase);

    // Randomized traffic against the reference model.
    rg = 0; rar = 0; rdr = 0; rsl = 8; rrr = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        rg = 1 - rg;
        $display("rand %0d: gate=%0d level=%0d phase=%0d", c, rg, bus.level, bus.phase);
      end
      if ($urandom_range(0, 63) == 0) begin
        rar = int'($urandom_range(0, 3));
        rdr = int'($urandom_range(0, 3));
        rrr = int'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) rsl = int'($urandom_range(0, 15));
      rrst = (c < 2 || $urandom_range(0, 599) == 0) ? 1 : 0;
      drive(rrst, rg, rar, rdr, rsl, rrr);
      model_edge(rrst, rg, rar, rdr, rsl, rrr);
      @(posedge clk); #1;
      check_outs($sformatf("rand@%0d", c), m_level, m_phase, m_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
